// File: rtl/launch_ctrl_if.sv
// launch_ctrl_if: launch request and boomed feedback between the
// firing controller (master) and the bomb block (slave).
interface launch_ctrl_if;
    logic       launch;
    logic [9:0] launchX;
    logic [9:0] launchY;
    logic       boomed;

    modport master (
        output launch,
        output launchX,
        output launchY,
        input  boomed
    );

    modport slave (
        input  launch,
        input  launchX,
        input  launchY,
        output boomed
    );
endinterface

// File: rtl/launch_ctrl.sv
// launch_ctrl: turn-based aim/charge/fire controller for two tanks.
// Optional turn timer (time_left port) when LAUNCH_CTRL_TURN_TIMER_EN is defined.
module launch_ctrl #(
    parameter logic [7:0] KEY_LEFT       = 8'h50,
    parameter logic [7:0] KEY_RIGHT      = 8'h4F,
    parameter logic [7:0] KEY_FIRE       = 8'h2C,
    parameter int         REPEAT_FRAMES  = 8,
    parameter int         CHARGE_FRAMES  = 10,
    parameter int         FLIGHT_TIMEOUT = 600,
    parameter int         SETTLE_FRAMES  = 2
`ifdef LAUNCH_CTRL_TURN_TIMER_EN
    ,
    parameter int         TURN_FRAMES    = 1800
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_tick,
    input  logic [7:0]    keycode,
    input  logic [9:0]    tank0_x,
    input  logic [9:0]    tank0_y,
    input  logic [9:0]    tank1_x,
    input  logic [9:0]    tank1_y,
    launch_ctrl_if.master bomb,
    output logic [3:0]    angle,
    output logic [2:0]    power,
    output logic          turn,
    output logic          busy
`ifdef LAUNCH_CTRL_TURN_TIMER_EN
    ,
    output logic [11:0]   time_left
`endif
);
    localparam logic [2:0] S_AIM    = 3'd0;
    localparam logic [2:0] S_CHARGE = 3'd1;
    localparam logic [2:0] S_FIRE   = 3'd2;
    localparam logic [2:0] S_FLIGHT = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;

    localparam int RW = $clog2(REPEAT_FRAMES + 1);
    localparam int CW = $clog2(CHARGE_FRAMES + 1);
    localparam int FW = $clog2(FLIGHT_TIMEOUT + 1);
    localparam int SW = $clog2(SETTLE_FRAMES + 1);

    localparam logic [RW-1:0] REP_RLD = RW'(REPEAT_FRAMES - 1);
    localparam logic [CW-1:0] CHG_MAX = CW'(CHARGE_FRAMES);
    localparam logic [FW-1:0] FLT_MAX = FW'(FLIGHT_TIMEOUT);
    localparam logic [SW-1:0] SET_MAX = SW'(SETTLE_FRAMES);

    logic [2:0]    r_state;
    logic          r_launch;
    logic [9:0]    r_lx;
    logic [9:0]    r_ly;
    logic [3:0]    r_angle;
    logic [2:0]    r_power;
    logic          r_turn;
    logic [RW-1:0] r_rep;
    logic [CW-1:0] r_chg;
    logic [FW-1:0] r_flt;
    logic [SW-1:0] r_set;
    logic          r_armed;

    logic          w_left;
    logic          w_right;
    logic          w_fire;
    logic          w_busy;
    logic          w_expire;
    logic          w_to_fire;
    logic          w_settle_done;
    logic [CW-1:0] w_chg_inc;
    logic [FW-1:0] w_flt_inc;
    logic [SW-1:0] w_set_inc;

    assign w_left    = (keycode == KEY_LEFT);
    assign w_right   = (keycode == KEY_RIGHT);
    assign w_fire    = (keycode == KEY_FIRE);
    assign w_busy    = (r_state == S_FIRE) || (r_state == S_FLIGHT)
                    || (r_state == S_SETTLE);
    assign w_chg_inc = r_chg + CW'(1);
    assign w_flt_inc = r_flt + FW'(1);
    assign w_set_inc = r_set + SW'(1);

    // Release during charge, or timer expiry, both launch with current aim
    assign w_to_fire = w_expire
                    || (r_state == S_CHARGE && frame_tick && !w_fire);
    assign w_settle_done = (r_state == S_SETTLE) && frame_tick
                        && (w_set_inc == SET_MAX);

`ifdef LAUNCH_CTRL_TURN_TIMER_EN
    localparam logic [11:0] TL_RLD = 12'(TURN_FRAMES);

    logic [11:0] r_tl;

    assign w_expire  = frame_tick && !w_busy && (r_tl == 12'd1);
    assign time_left = r_tl;

    always_ff @(posedge clk) begin
        if (!reset)
            r_tl <= TL_RLD;
        else if (w_settle_done)
            r_tl <= TL_RLD;
        else if (frame_tick && !w_busy && r_tl != 12'd0)
            r_tl <= r_tl - 12'd1;
    end
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_AIM;
            r_launch <= 1'b0;
            r_lx     <= '0;
            r_ly     <= '0;
            r_angle  <= 4'd6;
            r_power  <= 3'd0;
            r_turn   <= 1'b0;
            r_rep    <= '0;
            r_chg    <= '0;
            r_flt    <= '0;
            r_set    <= '0;
            r_armed  <= 1'b0;
        end else if (w_to_fire) begin
            r_state  <= S_FIRE;
            r_launch <= 1'b1;
            r_lx     <= r_turn ? tank1_x : tank0_x;
            r_ly     <= r_turn ? tank1_y : tank0_y;
        end else begin
            case (r_state)
                S_AIM: if (frame_tick) begin
                    if (w_fire) begin
                        r_state <= S_CHARGE;
                        r_power <= 3'd0;
                        r_chg   <= '0;
                        r_rep   <= '0;
                    end else if (w_left || w_right) begin
                        if (r_rep == '0) begin
                            r_rep <= REP_RLD;
                            if (w_left && r_angle != 4'd0)
                                r_angle <= r_angle - 4'd1;
                            if (w_right && r_angle != 4'd8)
                                r_angle <= r_angle + 4'd1;
                        end else begin
                            r_rep <= r_rep - RW'(1);
                        end
                    end else begin
                        r_rep <= '0;
                    end
                end
                S_CHARGE: if (frame_tick) begin
                    if (w_chg_inc == CHG_MAX) begin
                        r_chg <= '0;
                        if (r_power != 3'd7)
                            r_power <= r_power + 3'd1;
                    end else begin
                        r_chg <= w_chg_inc;
                    end
                end
                S_FIRE: if (frame_tick) begin
                    r_state  <= S_FLIGHT;
                    r_launch <= 1'b0;
                    r_armed  <= 1'b0;
                    r_flt    <= '0;
                end
                S_FLIGHT: begin
                    // A boomed left over from the previous shot must be ignored
                    if (!r_armed && !bomb.boomed)
                        r_armed <= 1'b1;
                    if ((r_armed && bomb.boomed)
                        || (frame_tick && w_flt_inc == FLT_MAX)) begin
                        r_state <= S_SETTLE;
                        r_set   <= '0;
                    end else if (frame_tick) begin
                        r_flt <= w_flt_inc;
                    end
                end
                S_SETTLE: if (frame_tick) begin
                    if (w_settle_done) begin
                        r_state <= S_AIM;
                        r_turn  <= !r_turn;
                        r_power <= 3'd0;
                        r_angle <= r_turn ? 4'd6 : 4'd2;
                        r_rep   <= '0;
                    end else begin
                        r_set <= w_set_inc;
                    end
                end
                default: r_state <= S_AIM;
            endcase
        end
    end

    assign bomb.launch  = r_launch;
    assign bomb.launchX = r_lx;
    assign bomb.launchY = r_ly;
    assign angle        = r_angle;
    assign power        = r_power;
    assign turn         = r_turn;
    assign busy         = w_busy;
endmodule

// File: tb/tb_launch_ctrl.sv
// tb_launch_ctrl: randomized bench for launch_ctrl against a
// tick-level behavioural model of aiming, charging and turn changes.
module tb_launch_ctrl;
    localparam logic [7:0] KL = 8'h50;
    localparam logic [7:0] KR = 8'h4F;
    localparam logic [7:0] KF = 8'h2C;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic [7:0] keycode;
    logic [9:0] t0x, t0y, t1x, t1y;
    logic [3:0] angle;
    logic [2:0] power;
    logic       turn;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    int m_angle, m_power, m_turn, m_run;

    launch_ctrl_if bif();

    always #5 clk = ~clk;

`ifdef LAUNCH_CTRL_TURN_TIMER_EN
    logic [11:0] time_left;
    logic [11:0] tl2;
    logic [3:0]  angle2;
    logic [2:0]  power2;
    logic        turn2, busy2;
    launch_ctrl_if bif2();

    launch_ctrl #(.TURN_FRAMES(5)) dut2 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .keycode(keycode),
        .tank0_x(t0x), .tank0_y(t0y), .tank1_x(t1x), .tank1_y(t1y),
        .bomb(bif2), .angle(angle2), .power(power2),
        .turn(turn2), .busy(busy2), .time_left(tl2)
    );
`endif

    launch_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .keycode(keycode),
        .tank0_x(t0x), .tank0_y(t0y), .tank1_x(t1x), .tank1_y(t1y),
        .bomb(bif), .angle(angle), .power(power),
        .turn(turn), .busy(busy)
`ifdef LAUNCH_CTRL_TURN_TIMER_EN
        , .time_left(time_left)
`endif
    );

    // Steps land on ticks 1, 9, 17, ... of an unbroken arrow run
    task automatic model_aim(input logic [7:0] k);
        if (k == KL || k == KR) begin
            m_run++;
            if ((m_run - 1) % 8 == 0) begin
                if (k == KL && m_angle > 0) m_angle--;
                if (k == KR && m_angle < 8) m_angle++;
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic model_settle();
        m_turn  = 1 - m_turn;
        m_angle = (m_turn == 0) ? 6 : 2;
        m_power = 0;
        m_run   = 0;
    endtask

    function automatic logic [7:0] aim_key();
        case ($urandom_range(0, 3))
            0: return 8'h00;
            1: return KL;
            2: return KR;
            default: return 8'h04;
        endcase
    endfunction

    function automatic logic [7:0] any_key();
        if ($urandom_range(0, 4) == 0) return KF;
        return aim_key();
    endfunction

    task automatic tick(input logic [7:0] k);
        @(negedge clk);
        keycode    = k;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        frame_tick = 1'b0;
        keycode = 8'h00;
        bif.boomed = 1'b1;
`ifdef LAUNCH_CTRL_TURN_TIMER_EN
        bif2.boomed = 1'b1;
`endif
        t0x = 10'd100; t0y = 10'd200;
        t1x = 10'd700; t1y = 10'd300;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        m_angle = 6; m_power = 0; m_turn = 0; m_run = 0;
        n_tests++;
        if (angle !== 4'd6) begin
            n_fail++;
            $display("FAIL reset_angle: got %0d want 6", angle);
        end
        n_tests++;
        if (power !== 3'd0 || turn !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pwr_turn_busy: got %0d/%0d/%0d want 0/0/0",
                     power, turn, busy);
        end
        n_tests++;
        if (bif.launch !== 1'b0 || bif.launchX !== 10'd0
            || bif.launchY !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_launch: got %0d/%0d/%0d want 0/0/0",
                     bif.launch, bif.launchX, bif.launchY);
        end
`ifdef LAUNCH_CTRL_TURN_TIMER_EN
        n_tests++;
        if (time_left !== 12'd1800) begin
            n_fail++;
            $display("FAIL reset_time_left: got %0d want 1800", time_left);
        end
`endif
    endtask

`ifdef LAUNCH_CTRL_TURN_TIMER_EN
    task automatic test_turn_timer();
        for (int i = 1; i <= 5; i++) begin
            tick(8'h00);
            model_aim(8'h00);
            n_tests++;
            if (bif2.launch !== (i == 5)) begin
                n_fail++;
                $display("FAIL timer_launch_t%0d: got %0d want %0d",
                         i, bif2.launch, (i == 5));
            end
        end
        n_tests++;
        if (angle2 !== 4'd6 || power2 !== 3'd0 || tl2 !== 12'd0) begin
            n_fail++;
            $display("FAIL timer_fire_aim: got a%0d p%0d t%0d want a6 p0 t0",
                     angle2, power2, tl2);
        end
        tick(8'h00);
        @(negedge clk) bif2.boomed = 1'b0;
        @(negedge clk) bif2.boomed = 1'b1;
        tick(8'h00);
        tick(8'h00);
        n_tests++;
        if (tl2 !== 12'd5 || busy2 !== 1'b0 || turn2 !== 1'b1) begin
            n_fail++;
            $display("FAIL timer_reload: got t%0d b%0d turn%0d want t5 b0 turn1",
                     tl2, busy2, turn2);
        end
        n_tests++;
        if (time_left !== 12'd1792) begin
            n_fail++;
            $display("FAIL timer_count: got %0d want 1792", time_left);
        end
    endtask
`endif

    task automatic test_angle_directed();
        int exp_a;
        for (int i = 1; i <= 20; i++) begin
            tick(KR);
            model_aim(KR);
            exp_a = (i < 9) ? 7 : 8;
            n_tests++;
            if (angle !== 4'(exp_a)) begin
                n_fail++;
                $display("FAIL angle_right_t%0d: got %0d want %0d",
                         i, angle, exp_a);
            end
        end
        tick(8'h00);
        model_aim(8'h00);
        tick(KL);
        model_aim(KL);
        n_tests++;
        if (angle !== 4'd7) begin
            n_fail++;
            $display("FAIL angle_left_step: got %0d want 7", angle);
        end
    endtask

    task automatic test_angle_random();
        logic [7:0] k;
        for (int i = 0; i < 60; i++) begin
            k = aim_key();
            tick(k);
            model_aim(k);
            n_tests++;
            if (angle !== 4'(m_angle)) begin
                n_fail++;
                $display("FAIL angle_rand_%0d: key %h got %0d want %0d",
                         i, k, angle, m_angle);
            end
        end
    endtask

    task automatic test_charge_fire();
        repeat (35) tick(KF);
        tick(8'h00);
        m_power = 3;
        m_run = 0;
        n_tests++;
        if (power !== 3'd3) begin
            n_fail++;
            $display("FAIL charge_power: got %0d want 3", power);
        end
        n_tests++;
        if (bif.launch !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL fire_entry: got l%0d b%0d want l1 b1",
                     bif.launch, busy);
        end
        n_tests++;
        if (bif.launchX !== t0x || bif.launchY !== t0y) begin
            n_fail++;
            $display("FAIL fire_pos_t0: got %0d,%0d want %0d,%0d",
                     bif.launchX, bif.launchY, t0x, t0y);
        end
        frame_tick = 1'b1;
        n_tests++;
        if (bif.launch !== 1'b1) begin
            n_fail++;
            $display("FAIL launch_in_tick: got %0d want 1", bif.launch);
        end
        @(negedge clk);
        frame_tick = 1'b0;
        n_tests++;
        if (bif.launch !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL launch_drop: got l%0d b%0d want l0 b1",
                     bif.launch, busy);
        end
    endtask

    task automatic test_flight_stale();
        for (int i = 0; i < 5; i++) begin
            tick(any_key());
            n_tests++;
            if (busy !== 1'b1 || angle !== 4'(m_angle)
                || power !== 3'(m_power)) begin
                n_fail++;
                $display("FAIL stale_%0d: got b%0d a%0d p%0d want b1 a%0d p%0d",
                         i, busy, angle, power, m_angle, m_power);
            end
        end
        @(negedge clk) bif.boomed = 1'b0;
        @(negedge clk) bif.boomed = 1'b1;
        tick(8'h00);
        n_tests++;
        if (busy !== 1'b1 || turn !== 1'b0) begin
            n_fail++;
            $display("FAIL settle_hold: got b%0d t%0d want b1 t0", busy, turn);
        end
        tick(8'h00);
        model_settle();
        n_tests++;
        if (turn !== 1'b1 || angle !== 4'd2 || power !== 3'd0
            || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL settle_done: got t%0d a%0d p%0d b%0d want t1 a2 p0 b0",
                     turn, angle, power, busy);
        end
    endtask

    task automatic test_timeout();
        int n;
        n = $urandom_range(1, 30);
        t1x = 10'($urandom_range(0, 1023));
        t1y = 10'($urandom_range(0, 1023));
        repeat (n) tick(KF);
        tick(8'h00);
        m_run = 0;
        m_power = ((n - 1) / 10 > 7) ? 7 : (n - 1) / 10;
        n_tests++;
        if (power !== 3'(m_power) || bif.launch !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_fire: got p%0d l%0d want p%0d l1",
                     power, bif.launch, m_power);
        end
        n_tests++;
        if (bif.launchX !== t1x || bif.launchY !== t1y) begin
            n_fail++;
            $display("FAIL fire_pos_t1: got %0d,%0d want %0d,%0d",
                     bif.launchX, bif.launchY, t1x, t1y);
        end
        bif.boomed = 1'b0;
        tick(8'h00);
        for (int i = 1; i <= 602; i++) begin
            tick(8'h00);
            if (i == 600 || i == 601) begin
                n_tests++;
                if (busy !== 1'b1 || turn !== 1'b1) begin
                    n_fail++;
                    $display("FAIL tmo_tick%0d: got b%0d t%0d want b1 t1",
                             i, busy, turn);
                end
            end
        end
        model_settle();
        n_tests++;
        if (turn !== 1'b0 || busy !== 1'b0 || angle !== 4'd6) begin
            n_fail++;
            $display("FAIL tmo_turn: got t%0d b%0d a%0d want t0 b0 a6",
                     turn, busy, angle);
        end
        bif.boomed = 1'b1;
    endtask

    task automatic play_turn(input int n_aim, input int n_fire,
                             input int n_stale);
        logic [7:0] k;
        t0x = 10'($urandom_range(0, 1023));
        t0y = 10'($urandom_range(0, 1023));
        t1x = 10'($urandom_range(0, 1023));
        t1y = 10'($urandom_range(0, 1023));
        for (int i = 0; i < n_aim; i++) begin
            k = aim_key();
            tick(k);
            model_aim(k);
            n_tests++;
            if (angle !== 4'(m_angle)) begin
                n_fail++;
                $display("FAIL turn_aim: key %h got %0d want %0d",
                         k, angle, m_angle);
            end
        end
        repeat (n_fire) tick(KF);
        m_run = 0;
        tick(8'h00);
        m_power = ((n_fire - 1) / 10 > 7) ? 7 : (n_fire - 1) / 10;
        n_tests++;
        if (power !== 3'(m_power) || bif.launch !== 1'b1) begin
            n_fail++;
            $display("FAIL turn_fire: n%0d got p%0d l%0d want p%0d l1",
                     n_fire, power, bif.launch, m_power);
        end
        n_tests++;
        if (bif.launchX !== (m_turn ? t1x : t0x)
            || bif.launchY !== (m_turn ? t1y : t0y)) begin
            n_fail++;
            $display("FAIL turn_pos: got %0d,%0d want %0d,%0d",
                     bif.launchX, bif.launchY,
                     m_turn ? t1x : t0x, m_turn ? t1y : t0y);
        end
        tick(8'h00);
        for (int i = 0; i < n_stale; i++) tick(any_key());
        n_tests++;
        if (bif.launch !== 1'b0 || busy !== 1'b1
            || angle !== 4'(m_angle) || power !== 3'(m_power)) begin
            n_fail++;
            $display("FAIL turn_flight: got l%0d b%0d a%0d p%0d want l0 b1 a%0d p%0d",
                     bif.launch, busy, angle, power, m_angle, m_power);
        end
        @(negedge clk) bif.boomed = 1'b0;
        @(negedge clk) bif.boomed = 1'b1;
        tick(8'h00);
        tick(8'h00);
        model_settle();
        n_tests++;
        if (turn !== 1'(m_turn) || angle !== 4'(m_angle)
            || power !== 3'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL turn_end: got t%0d a%0d p%0d b%0d want t%0d a%0d p0 b0",
                     turn, angle, power, busy, m_turn, m_angle);
        end
    endtask

    task automatic test_reset_in_flight();
        play_turn(3, 5, 2);
        tick(KF);
        tick(8'h00);
        tick(8'h00);
        n_tests++;
        if (busy !== 1'b1 || turn !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_flight: got b%0d t%0d want b1 t1",
                     busy, turn);
        end
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        m_angle = 6; m_power = 0; m_turn = 0; m_run = 0;
        n_tests++;
        if (turn !== 1'b0 || angle !== 4'd6 || bif.launch !== 1'b0
            || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_flight: got t%0d a%0d l%0d b%0d want t0 a6 l0 b0",
                     turn, angle, bif.launch, busy);
        end
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 6; t++)
            play_turn($urandom_range(0, 20), $urandom_range(1, 85),
                      $urandom_range(0, 4));
    endtask

    initial begin
        test_reset();
`ifdef LAUNCH_CTRL_TURN_TIMER_EN
        test_turn_timer();
`endif
        test_angle_directed();
        test_angle_random();
        test_charge_fire();
        test_flight_stale();
        test_timeout();
        test_reset_in_flight();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/launch_ctrl.md
Name: launch_ctrl

Overview:
- Turn-based firing controller; it is the initiator side of the bomb launch/boomed interface.
- Aims per player: angle from arrow keys, power from a space-bar hold-to-charge.
- Issues a launch request held until the next frame tick, then waits for the projectile to detonate and the terrain to settle.
- Hands the turn to the other tank; sits between the keyboard decoder, the two tank blocks and the bomb block.

Parameters:
KEY_LEFT, 8'h50, keycode that decrements angle
KEY_RIGHT, 8'h4F, keycode that increments angle
KEY_FIRE, 8'h2C, keycode for charge/fire (space)
REPEAT_FRAMES, 8, frame ticks between angle steps while an arrow is held
CHARGE_FRAMES, 10, frame ticks per power increment while fire is held
FLIGHT_TIMEOUT, 600, frame ticks in FLIGHT before a forced detonation assumption
SETTLE_FRAMES, 2, frame ticks waited after boom before the turn changes

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (0 = reset)
frame_tick  in  1  one-clk strobe per video frame, synchronous to clk
keycode  in  8  currently pressed key, 0 = none
boomed  in  1  projectile exploded/idle flag from bomb block
tank0_x, tank0_y  in  10 each  tank 0 muzzle position
tank1_x, tank1_y  in  10 each  tank 1 muzzle position
launch  out  1  launch request to bomb block
launchX, launchY  out  10 each  launch position, latched at FIRE entry
angle  out  4  aim index 0..8 (0 = left horizontal, 4 = up, 8 = right horizontal)
power  out  3  launch power 0..7
turn  out  1  active player
busy  out  1  high in FIRE, FLIGHT, SETTLE (input ignored)

Behaviour:
- All state updates on posedge clk. reset==0 sampled on a clock edge has priority over everything, including mid-flight. Reset values: state=AIM, launch=0, launchX=launchY=0, angle=6, power=0, turn=0, busy=0, all counters 0.
- Key decode: left=(keycode==KEY_LEFT), right=(keycode==KEY_RIGHT), fire=(keycode==KEY_FIRE).
- AIM:
  - On a frame_tick with fire: go to CHARGE, power=0, charge counter=0. Fire wins over arrows on the same tick.
  - Otherwise on a frame_tick with exactly one arrow held:
    - If the repeat counter is 0, step the angle (left: -1, right: +1) and set the counter to REPEAT_FRAMES-1.
    - If the counter is nonzero, decrement it.
  - Angle saturates at 0 and 8; no wrap.
  - Neither arrow, or both arrows: the repeat counter clears to 0 and the angle holds.
- CHARGE:
  - On each frame_tick with fire held, the charge counter increments. When it reaches CHARGE_FRAMES it clears and power increments, saturating at 7.
  - On the first frame_tick with fire released: go to FIRE. Latch launchX/launchY from the current turn's tank (turn 0 → tank0, turn 1 → tank1). Set launch=1.
- FIRE:
  - launch stays 1 through the clk cycle in which frame_tick=1, so the bomb block samples it on its frame edge.
  - On that cycle, state → FLIGHT with armed=0 and the flight counter cleared.
  - launch is 0 from the next cycle.
- FLIGHT:
  - armed sets when boomed==0 is seen. A stale boomed==1 before armed is ignored.
  - When armed and boomed==1, go to SETTLE.
  - The flight counter increments per frame_tick; reaching FLIGHT_TIMEOUT also goes to SETTLE.
- SETTLE: count SETTLE_FRAMES frame ticks, then:
  - turn toggles and power=0;
  - angle = 6 if the new turn is 0, else 2;
  - state → AIM.
- Invariants:
  - busy = (state ∈ {FIRE, FLIGHT, SETTLE}).
  - angle and power never change while busy.
  - launch is never 1 outside FIRE.
  - Counters are sized to hold their parameter without overflow.

Optional Feature:
- Macro: LAUNCH_CTRL_TURN_TIMER_EN.
- Enabled:
  - Adds parameter TURN_FRAMES (default 1800) and output time_left[11:0].
  - time_left reloads to TURN_FRAMES on every AIM entry and reset, and decrements per frame_tick in AIM/CHARGE.
  - On a frame_tick where it is 1 it becomes 0, and FIRE is entered immediately with the current angle/power.
  - It holds its value while busy.
- Disabled: no time_left port; turns are unlimited.

Test Plan:
- Reset, then keycode=8'h4F for 20 frame ticks → angle 6→7 at tick 1, 7→8 at tick 9, holds 8 (saturation); release, then 8'h50 one tick → 7.
- Hold keycode=8'h2C for 35 ticks, release → power=3 (increments at ticks 11, 21, 31). Next cycle state=FIRE, launch=1, launchX/Y=tank0 position. launch is high through the next frame_tick cycle and low the cycle after.
- FLIGHT with boomed held 1 (stale) for 5 ticks → stays FLIGHT. boomed 0 then 1 → SETTLE; after 2 ticks turn=1, angle=2, power=0, busy=0.
- boomed held 0 for whole flight → SETTLE entered on frame tick 600; turn toggles after settle.
- Assert reset=0 one cycle during FLIGHT with turn=1 → next cycle state AIM, turn=0, angle=6, launch=0, busy=0.
- Timer enabled, TURN_FRAMES=5, no keys → at 5th tick launch=1 with angle=6, power=0; time_left=5 again on the next AIM entry.
